reg_file_param: RTL and testbench

Parametrised successor to the CPU register file: `DEPTH = 2**ADDR_WIDTH` entries of `DATA_WIDTH` bits, two asynchronous read ports and one synchronous write port gated by instruction-valid. Adds an optional hardwired-zero entry 0 and optional same-cycle write-to-read bypass. It also adds a memory-friendly clear sequencer that wipes one entry per cycle after reset or on request, instead of an all-at-once clear. It sits in the ID stage of the RISC-V pipeline, and writeback drives the write port.

---
 rtl/reg_file_param_if.sv | 27 ++
 rtl/reg_file_param.sv | 108 ++++++++++
 tb/tb_reg_file_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// Register-file access bundle: writeback write port, two read ports, clear request and status.
interface reg_file_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  WRITE;
  logic                  InstHIT;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic [DATA_WIDTH-1:0] IN;
  logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
  logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
  logic [DATA_WIDTH-1:0] OUT1;
  logic [DATA_WIDTH-1:0] OUT2;
  logic                  CLEAR;
  logic                  READY;
  logic                  DROPPED;

  modport master (
    output WRITE, InstHIT, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    input  OUT1, OUT2, READY, DROPPED
  );

  modport slave (
    input  WRITE, InstHIT, INADDRESS, IN, OUT1ADDRESS, OUT2ADDRESS, CLEAR,
    output OUT1, OUT2, READY, DROPPED
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: 2 async read ports, 1 gated sync write port,
// optional hardwired r0 and write bypass, one-entry-per-cycle clear sweep.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  reg_file_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic                  r_dropped;
  logic                  w_drop;
  logic                  w_wreq;
  logic                  w_ready;
  logic                  w_arr_we;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic [DATA_WIDTH-1:0] w_arr_dat;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_wreq  = bus.WRITE & bus.InstHIT;
  assign w_ready = (r_state == IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= SWEEP;
      r_ptr     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_dropped <= w_drop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_drop      = 1'b0;
    w_arr_we    = 1'b0;
    w_arr_addr  = r_ptr;
    w_arr_dat   = '0;
    case (r_state)
      SWEEP: begin
        w_arr_we = 1'b1;
        w_drop   = w_wreq;
        if (bus.CLEAR) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == LAST_PTR) begin
          w_state_nxt = IDLE;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (bus.CLEAR) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = '0;
          w_drop      = w_wreq;
        end else if (w_wreq && !((ZERO_REG != 0) && (bus.INADDRESS == '0))) begin
          // r0 writes with ZERO_REG are discarded silently, not reported as dropped
          w_arr_we   = 1'b1;
          w_arr_addr = bus.INADDRESS;
          w_arr_dat  = bus.IN;
        end
      end
    endcase
  end

  // Array has no reset: contents only change through the sweep or writeback.
  always_ff @(posedge CLK) begin
    if (w_arr_we && !RESET) begin
      r_mem[w_arr_addr] <= w_arr_dat;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] f_read(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  ready,
    input logic                  wreq,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdat
  );
    if (!ready)                                   return '0;
    if ((ZERO_REG != 0) && (addr == '0))          return '0;
    if ((BYPASS != 0) && wreq && (waddr == addr)) return wdat;
    return stored;
  endfunction

  assign bus.OUT1    = f_read(bus.OUT1ADDRESS, r_mem[bus.OUT1ADDRESS], w_ready,
                              w_wreq, bus.INADDRESS, bus.IN);
  assign bus.OUT2    = f_read(bus.OUT2ADDRESS, r_mem[bus.OUT2ADDRESS], w_ready,
                              w_wreq, bus.INADDRESS, bus.IN);
  assign bus.READY   = w_ready;
  assign bus.DROPPED = r_dropped;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: default DUT (r0 hardwired, bypass) and a plain DUT side by side.
module tb_reg_file_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  reg_file_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

  reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_a (
    .CLK(clk), .RESET(rst), .bus(bus_a.slave));
  reg_file_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) u_b (
    .CLK(clk), .RESET(rst), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic wr, input logic hit, input logic [4:0] waddr,
                     input logic [31:0] wdat, input logic [4:0] a1, input logic [4:0] a2,
                     input logic clr);
    bus_a.WRITE = wr;  bus_a.InstHIT = hit; bus_a.INADDRESS = waddr; bus_a.IN = wdat;
    bus_a.OUT1ADDRESS = a1; bus_a.OUT2ADDRESS = a2; bus_a.CLEAR = clr;
    bus_b.WRITE = wr;  bus_b.InstHIT = hit; bus_b.INADDRESS = waddr; bus_b.IN = wdat;
    bus_b.OUT1ADDRESS = a1; bus_b.OUT2ADDRESS = a2; bus_b.CLEAR = clr;
    #1;
  endtask

  // Inputs change and outputs are sampled 2-3 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drv(0, 0, 5'd0, 32'h0, 5'd0, 5'd5, 0);
    #12;
    chk("rst_ready_a",   32'(bus_a.READY),   32'd0);
    chk("rst_dropped_a", 32'(bus_a.DROPPED), 32'd0);
    chk("rst_out1_a",    bus_a.OUT1,         32'h0);
    chk("rst_out2_b",    bus_b.OUT2,         32'h0);

    // Reset sweep: READY rises on the 32nd edge after release
    @(negedge clk);
    rst = 1'b0;
    repeat (31) step();
    chk("sweep31_ready_a", 32'(bus_a.READY), 32'd0);
    chk("sweep31_ready_b", 32'(bus_b.READY), 32'd0);
    step();
    chk("sweep32_ready_a", 32'(bus_a.READY), 32'd1);
    for (int i = 0; i < 32; i++) begin
      drv(0, 0, 5'd0, 32'h0, 5'(i), 5'(i), 0);
      chk($sformatf("swept_a_r%0d", i), bus_a.OUT1, 32'h0);
      chk($sformatf("swept_b_r%0d", i), bus_b.OUT2, 32'h0);
    end

    // Write r5 with same-cycle read: bypass DUT forwards, plain DUT shows old value
    drv(1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 0);
    chk("byp_pre_a", bus_a.OUT1, 32'hDEADBEEF);
    chk("byp_pre_b", bus_b.OUT1, 32'h0);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0);
    chk("wr5_post_a", bus_a.OUT1, 32'hDEADBEEF);
    chk("wr5_post_b", bus_b.OUT1, 32'hDEADBEEF);
    chk("wr5_drop_a", 32'(bus_a.DROPPED), 32'd0);

    // Zero register
    drv(1, 1, 5'd0, 32'h12345678, 5'd5, 5'd0, 0);
    chk("r0_pre_a", bus_a.OUT2, 32'h0);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0);
    chk("r0_post_a",  bus_a.OUT2, 32'h0);
    chk("r0_drop_a",  32'(bus_a.DROPPED), 32'd0);
    chk("r0_post_b",  bus_b.OUT2, 32'h12345678);

    // InstHIT gating
    drv(1, 0, 5'd7, 32'h55, 5'd7, 5'd0, 0);
    chk("hit_pre_a", bus_a.OUT1, 32'h0);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 0);
    chk("hit_r7_a",   bus_a.OUT1, 32'h0);
    chk("hit_r7_b",   bus_b.OUT1, 32'h0);
    chk("hit_drop_a", 32'(bus_a.DROPPED), 32'd0);

    // CLEAR wins over a simultaneous write
    drv(1, 1, 5'd3, 32'hA5, 5'd3, 5'd4, 0);
    step();
    drv(1, 1, 5'd4, 32'hBB, 5'd3, 5'd4, 1);
    chk("clr_pre_r3_a", bus_a.OUT1, 32'hA5);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd3, 5'd4, 0);
    chk("clr_drop_a",  32'(bus_a.DROPPED), 32'd1);
    chk("clr_drop_b",  32'(bus_b.DROPPED), 32'd1);
    chk("clr_ready_a", 32'(bus_a.READY),   32'd0);
    chk("clr_out1_a",  bus_a.OUT1,         32'h0);
    step();
    chk("clr_drop_end_a", 32'(bus_a.DROPPED), 32'd0);
    repeat (30) step();
    chk("clr31_ready_a", 32'(bus_a.READY), 32'd0);
    step();
    chk("clr32_ready_a", 32'(bus_a.READY), 32'd1);
    chk("clr_r3_a", bus_a.OUT1, 32'h0);
    chk("clr_r4_b", bus_b.OUT2, 32'h0);
    drv(0, 0, 5'd0, 32'h0, 5'd5, 5'd0, 0);
    chk("clr_r5_a", bus_a.OUT1, 32'h0);
    chk("clr_r5_b", bus_b.OUT1, 32'h0);
    chk("clr_r0_b", bus_b.OUT2, 32'h0);

    // Reset at ptr=10, then a dropped write during the fresh sweep
    drv(1, 1, 5'd20, 32'h2020, 5'd20, 5'd6, 0);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd20, 5'd6, 1);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd20, 5'd6, 0);
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready_a",   32'(bus_a.READY),   32'd0);
    chk("mid_rst_dropped_a", 32'(bus_a.DROPPED), 32'd0);
    step();
    rst = 1'b0;
    drv(1, 1, 5'd6, 32'h66, 5'd20, 5'd6, 0);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd20, 5'd6, 0);
    chk("sw_drop_a", 32'(bus_a.DROPPED), 32'd1);
    chk("sw_drop_b", 32'(bus_b.DROPPED), 32'd1);
    step();
    chk("sw_drop_end_a", 32'(bus_a.DROPPED), 32'd0);
    repeat (29) step();
    chk("rst31_ready_a", 32'(bus_a.READY), 32'd0);
    step();
    chk("rst32_ready_a", 32'(bus_a.READY), 32'd1);
    chk("rst_r20_a", bus_a.OUT1, 32'h0);
    chk("rst_r20_b", bus_b.OUT1, 32'h0);
    chk("rst_r6_a",  bus_a.OUT2, 32'h0);

    // First write after the sweep lands normally
    drv(1, 1, 5'd6, 32'h0F0F0F0F, 5'd6, 5'd6, 0);
    step();
    drv(0, 0, 5'd0, 32'h0, 5'd6, 5'd6, 0);
    chk("post_r6_a", bus_a.OUT1, 32'h0F0F0F0F);
    chk("post_r6_b", bus_b.OUT2, 32'h0F0F0F0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
